// File: rtl/gate_net_sequencer_pkg.sv
// Shared constants, FSM state type and golden Y function for the gate-network sequencer.
package gns_pkg;

    localparam int VEC_W = 6;

    localparam int A_BIT = 5;
    localparam int B_BIT = 4;
    localparam int C_BIT = 3;
    localparam int D_BIT = 2;
    localparam int E_BIT = 1;
    localparam int F_BIT = 0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } gns_state_e;

    function automatic logic gns_expected(input logic [VEC_W-1:0] vec);
        logic a, b, c, d, e, f;
        a = vec[A_BIT];
        b = vec[B_BIT];
        c = vec[C_BIT];
        d = vec[D_BIT];
        e = vec[E_BIT];
        f = vec[F_BIT];
        return ~(~(a & b) & (c & ~b & d) & ~(e | f));
    endfunction

endpackage

// File: rtl/gate_net_sequencer_if.sv
// Client/network bundle for gate_net_sequencer; mismatch exists only when GNS_CHECK_EN is defined.
interface gate_net_sequencer_if #(
    parameter int NREQ = 4
);
    import gns_pkg::*;

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [VEC_W*NREQ-1:0] vec_in;
    logic [NREQ-1:0]       gnt;
    logic [VEC_W-1:0]      net_in;
    logic                  net_y;
    logic                  busy;
    logic                  done;
    logic [IDX_W-1:0]      done_id;
    logic                  y_out;
`ifdef GNS_CHECK_EN
    logic                  mismatch;

    modport master (
        output req, vec_in, net_y,
        input  gnt, net_in, busy, done, done_id, y_out, mismatch
    );

    modport slave (
        input  req, vec_in, net_y,
        output gnt, net_in, busy, done, done_id, y_out, mismatch
    );
`else
    modport master (
        output req, vec_in, net_y,
        input  gnt, net_in, busy, done, done_id, y_out
    );

    modport slave (
        input  req, vec_in, net_y,
        output gnt, net_in, busy, done, done_id, y_out
    );
`endif

endinterface

// File: rtl/gate_net_sequencer_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer; pointer moves past the winner on take.
module gns_rr_arbiter
    import gns_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  i_req,
    input  logic             i_take,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] r_ptr;
    int               w_pos;

    always_comb begin
        w_pos = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = (int'(r_ptr) + k) % NREQ;
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = IDX_W'(w_pos);
            end
        end
    end

    // explicit wrap so non-power-of-two NREQ stays in range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_take) begin
            r_ptr <= (int'(o_idx) == NREQ - 1) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/gate_net_sequencer.sv
// Shares one combinational gate network among NREQ requesters, holding each vector SETTLE cycles.
// Optional golden-model compare of net_y is enabled by defining GNS_CHECK_EN.
module gate_net_sequencer
    import gns_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int SETTLE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_net_sequencer_if.slave  bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(SETTLE) + 1;

    gns_state_e       r_state;
    gns_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_cur_id;
    logic [NREQ-1:0]  r_gnt;
    logic [VEC_W-1:0] r_net_in;
    logic             r_busy;
    logic             r_done;
    logic [IDX_W-1:0] r_done_id;
    logic             r_y_out;

    logic             w_take;
    logic             w_sample;
    logic [NREQ-1:0]  w_arb_gnt;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_any;

    gns_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req  (bus.req),
        .i_take (w_take),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx),
        .o_any  (w_arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // req is only looked at in IDLE, so changes during SETTLE are ignored
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_sample    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt     <= '0;
            r_net_in  <= '0;
            r_cnt     <= '0;
            r_cur_id  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_y_out   <= 1'b0;
        end else begin
            r_gnt  <= w_take ? w_arb_gnt : '0;
            r_done <= w_sample;
            if (w_take) begin
                r_net_in <= bus.vec_in[VEC_W*w_arb_idx +: VEC_W];
                r_cnt    <= CNT_W'(SETTLE - 1);
                r_cur_id <= w_arb_idx;
                r_busy   <= 1'b1;
            end else if (r_state == ST_SETTLE && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_sample) begin
                r_y_out   <= bus.net_y;
                r_done_id <= r_cur_id;
                r_busy    <= 1'b0;
            end
        end
    end

`ifdef GNS_CHECK_EN
    logic r_mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mismatch <= 1'b0;
        end else if (w_sample) begin
            r_mismatch <= (bus.net_y != gns_expected(r_net_in));
        end
    end

    assign bus.mismatch = r_mismatch;
`endif

    assign bus.gnt     = r_gnt;
    assign bus.net_in  = r_net_in;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.y_out   = r_y_out;

endmodule

// File: tb/tb_gate_net_sequencer.sv
// Scoreboard bench for gate_net_sequencer: directed vectors with hand-computed Y, grant order and timing.
module tb_gate_net_sequencer;

    localparam int NREQ   = 4;
    localparam int SETTLE = 4;

    typedef struct {
        int         id;
        logic [5:0] vec;
    } gnt_exp_t;

    typedef struct {
        int   id;
        logic y;
        logic mis;
    } done_exp_t;

    logic clk;
    logic rst_n;
    logic force_zero;
    int   cyc;
    int   total;
    int   bad;
    int   mon_last_gnt;

    gnt_exp_t  gq[$];
    done_exp_t dq[$];

    gate_net_sequencer_if #(.NREQ(NREQ)) bus ();

    gate_net_sequencer #(
        .NREQ   (NREQ),
        .SETTLE (SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // stand-in gate network, with a stuck-at-0 override on Y
    assign bus.net_y = force_zero ? 1'b0 :
        ~(~(bus.net_in[5] & bus.net_in[4]) &
          (bus.net_in[3] & ~bus.net_in[4] & bus.net_in[2]) &
          ~(bus.net_in[1] | bus.net_in[0]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (|bus.gnt) begin
            if (gq.size() == 0) begin
                check("unexpected_gnt", 32'(bus.gnt), 32'h0);
            end else begin
                gnt_exp_t g;
                g = gq.pop_front();
                check("gnt_onehot", 32'(bus.gnt), 32'(1) << g.id);
                check("net_in", 32'(bus.net_in), 32'(g.vec));
                check("busy_at_gnt", 32'(bus.busy), 32'h1);
                mon_last_gnt = cyc;
            end
        end
        if (bus.done) begin
            if (dq.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'h0);
            end else begin
                done_exp_t d;
                d = dq.pop_front();
                check("done_id", 32'(bus.done_id), 32'(d.id));
                check("y_out", 32'(bus.y_out), 32'(d.y));
                check("done_latency", 32'(cyc - mon_last_gnt), 32'(SETTLE));
                check("busy_at_done", 32'(bus.busy), 32'h0);
`ifdef GNS_CHECK_EN
                check("mismatch", 32'(bus.mismatch), 32'(d.mis));
`endif
            end
        end
    end

    task automatic wait_evt(input bit want_done, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (want_done ? bus.done : (|bus.gnt)) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: got none expected event within 30 cycles", want_done ? "done" : "gnt");
        end
    endtask

    task automatic run_single(input int id, input logic [5:0] vec, input logic y, input logic mis);
        bit ok;
        bus.vec_in[6*id +: 6] = vec;
        bus.req[id] = 1'b1;
        gq.push_back('{id: id, vec: vec});
        dq.push_back('{id: id, y: y, mis: mis});
        wait_evt(1'b0, ok);
        bus.req[id] = 1'b0;
        wait_evt(1'b1, ok);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt"},     32'(bus.gnt), 32'h0);
        check({tag, "_net_in"},  32'(bus.net_in), 32'h0);
        check({tag, "_busy"},    32'(bus.busy), 32'h0);
        check({tag, "_done"},    32'(bus.done), 32'h0);
        check({tag, "_done_id"}, 32'(bus.done_id), 32'h0);
        check({tag, "_y_out"},   32'(bus.y_out), 32'h0);
`ifdef GNS_CHECK_EN
        check({tag, "_mismatch"}, 32'(bus.mismatch), 32'h0);
`endif
    endtask

    initial begin
        bit ok;
        int t_prev;
        int t_done;
        logic [5:0] rr_vec [4];
        logic       rr_y   [4];

        cyc          = 0;
        total        = 0;
        bad          = 0;
        mon_last_gnt = 0;
        force_zero   = 1'b0;
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.vec_in   = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // all four requesters together: order 0,1,2,3,0 spaced SETTLE+1
        rr_vec[0] = 6'b100100; rr_y[0] = 1'b1;
        rr_vec[1] = 6'b001100; rr_y[1] = 1'b0;
        rr_vec[2] = 6'b100101; rr_y[2] = 1'b1;
        rr_vec[3] = 6'b101100; rr_y[3] = 1'b0;
        for (int i = 0; i < 4; i++) bus.vec_in[6*i +: 6] = rr_vec[i];
        for (int k = 0; k < 5; k++) begin
            gq.push_back('{id: k % 4, vec: rr_vec[k % 4]});
            dq.push_back('{id: k % 4, y: rr_y[k % 4], mis: 1'b0});
        end
        bus.req = 4'b1111;
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_evt(1'b0, ok);
            if (k > 0) check("rr_spacing", 32'(cyc - t_prev), 32'(SETTLE + 1));
            t_prev = cyc;
        end
        bus.req = '0;
        wait_evt(1'b1, ok);
        @(negedge clk);

        // single requests with hand-computed Y
        run_single(0, 6'b100100, 1'b1, 1'b0);
        run_single(0, 6'b001100, 1'b0, 1'b0);
        run_single(0, 6'b100101, 1'b1, 1'b0);
        force_zero = 1'b1;
        run_single(0, 6'b100101, 1'b0, 1'b1);
        force_zero = 1'b0;

        // req[2] raised during requester 1's settle window
        bus.vec_in[6 +: 6] = 6'b001100;
        bus.req[1] = 1'b1;
        gq.push_back('{id: 1, vec: 6'b001100});
        dq.push_back('{id: 1, y: 1'b0, mis: 1'b0});
        wait_evt(1'b0, ok);
        bus.req[1] = 1'b0;
        @(negedge clk);
        bus.vec_in[12 +: 6] = 6'b100101;
        bus.req[2] = 1'b1;
        gq.push_back('{id: 2, vec: 6'b100101});
        dq.push_back('{id: 2, y: 1'b1, mis: 1'b0});
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (bus.done) ok = 1'b1;
            else begin
                check("settle_net_in_held", 32'(bus.net_in), 32'h0C);
                check("settle_no_gnt", 32'(bus.gnt), 32'h0);
            end
        end
        if (!ok) check("timeout_mid_done", 32'h0, 32'h1);
        t_done = cyc;
        wait_evt(1'b0, ok);
        check("gnt_after_done", 32'(cyc - t_done), 32'h1);
        bus.req[2] = 1'b0;
        wait_evt(1'b1, ok);
        @(negedge clk);

        // reset two cycles after a grant: no done for the aborted vector
        bus.vec_in[6 +: 6] = 6'b100100;
        bus.req[1] = 1'b1;
        gq.push_back('{id: 1, vec: 6'b100100});
        wait_evt(1'b0, ok);
        bus.req[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        run_single(3, 6'b100100, 1'b1, 1'b0);
        repeat (4) @(negedge clk);

        check("gq_drained", 32'(gq.size()), 32'h0);
        check("dq_drained", 32'(dq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1, "global timeout");
    end

endmodule
